// File: rtl/imu_frame_tx.sv
// ============================================================================
//  Module      : imu_frame_tx
//  Description : Periodic IMU sample framer. Every SAMPLE_DIV clocks it
//                captures the three signed axes and sends a 9-byte frame
//                (sync, seq, ax, ay, az big-endian, check byte) on a
//                byte-wide valid/ready stream.
//                Optional macro IMU_FRAME_CRC8_EN: the check byte is a CRC-8
//                (poly 0x07, init 0x00) instead of the 8-bit additive sum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imu_frame_tx #(
    parameter int         WIDTH      = 16,
    parameter int         SAMPLE_DIV = 1000,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] ax,
    input  logic signed [WIDTH-1:0] ay,
    input  logic signed [WIDTH-1:0] az,
    output logic                    out_valid,
    output logic [7:0]              out_data,
    input  logic                    out_ready,
    output logic                    frame_done,
    output logic [7:0]              overrun_cnt
);

    localparam int                 c_CNT_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(SAMPLE_DIV - 1);
    localparam logic [3:0]         c_LAST_IDX  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_tick_cnt;
    logic               w_tick;
    logic [3:0]         r_idx;
    logic [3:0]         w_idx_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [7:0]         r_seq;
    logic [7:0]         w_seq_nxt;
    logic               w_capture;
    logic               w_drop;
    logic               w_accept;
    logic [7:0]         r_overrun;
    logic [7:0]         r_frame [0:8];

    logic [15:0]        w_ax16;
    logic [15:0]        w_ay16;
    logic [15:0]        w_az16;
    logic [55:0]        w_msg;
    logic [7:0]         w_check;

    // Bytes 1..7 of the frame, most significant byte first.
    assign w_ax16 = 16'(ax);
    assign w_ay16 = 16'(ay);
    assign w_az16 = 16'(az);
    assign w_msg  = {r_seq, w_ax16, w_ay16, w_az16};

`ifdef IMU_FRAME_CRC8_EN
    // Bit-serial CRC-8, MSB first, poly x^8+x^2+x+1, zero init, no final XOR.
    function automatic logic [7:0] crc8(input logic [55:0] msg);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 55; i >= 0; i--) begin
            fb = c[7] ^ msg[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    assign w_check = crc8(w_msg);
`else
    // Modulo-256 sum of the seven payload bytes.
    function automatic logic [7:0] sum8(input logic [55:0] msg);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 7; i++) begin
            s = s + msg[i*8 +: 8];
        end
        return s;
    endfunction

    assign w_check = sum8(w_msg);
`endif

    // Sample tick: the last count of each SAMPLE_DIV period, only while enabled.
    assign w_tick   = enable && (r_tick_cnt == c_TICK_LAST);
    assign w_accept = r_valid && out_ready;

    // Free-running sample divider; held at zero while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (!enable || (r_tick_cnt == c_TICK_LAST)) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Next-state and handshake decisions for the IDLE/SEND machine.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        w_seq_nxt   = r_seq;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_SEND;
                    w_idx_nxt   = 4'd0;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_SEND: begin
                // A tick arriving while a frame is still draining is lost.
                w_drop = w_tick;
                if (w_accept) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_seq_nxt   = r_seq + 8'd1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, byte index, handshake flags and sequence number registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_seq   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_seq   <= w_seq_nxt;
        end
    end

    // Frame capture on the accepted tick; contents frozen until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                r_frame[i] <= 8'h00;
            end
        end else if (w_capture) begin
            r_frame[0] <= SYNC_BYTE;
            r_frame[1] <= r_seq;
            r_frame[2] <= w_ax16[15:8];
            r_frame[3] <= w_ax16[7:0];
            r_frame[4] <= w_ay16[15:8];
            r_frame[5] <= w_ay16[7:0];
            r_frame[6] <= w_az16[15:8];
            r_frame[7] <= w_az16[7:0];
            r_frame[8] <= w_check;
        end
    end

    // Saturating count of ticks dropped while a frame was in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun <= 8'd0;
        end else if (w_drop && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    // The index stays on the last presented byte after a frame, so out_data
    // holds its final value while idle; reset clears the frame to zero.
    assign out_data    = r_frame[r_idx];
    assign out_valid   = r_valid;
    assign frame_done  = r_done;
    assign overrun_cnt = r_overrun;

endmodule

`default_nettype wire
